// File: rtl/noise_histogram_dump_pkg.sv
// Shared FSM state type, dump geometry constants and the saturating increment
// used by noise_histogram_dump and hist_bin_bank.
package noise_hist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DUMP  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BIN_OFFSET     = 64;
  localparam int WORDS_PER_DUMP = 32;
  localparam int BINS_PER_WORD  = 4;

  // Increment v, sticking at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/noise_histogram_dump_bin_bank.sv
// hist_bin_bank: register array of saturating occurrence counters with a
// bulk clear, one indexed increment per cycle and a 4-bin read port.
module hist_bin_bank
  import noise_hist_pkg::*;
#(
  parameter  int NUM_BINS = 128,
  parameter  int CNT_W    = 16,
  localparam int IDX_W    = $clog2(NUM_BINS),
  localparam int WIDX_W   = $clog2(NUM_BINS / BINS_PER_WORD)
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           i_clr,
  input  logic                           i_inc,
  input  logic [IDX_W-1:0]               i_inc_idx,
  input  logic [WIDX_W-1:0]              i_word_idx,
  output logic [BINS_PER_WORD*CNT_W-1:0] o_rd_word
);

  logic [CNT_W-1:0] r_bin [NUM_BINS];
  logic [IDX_W-1:0] w_rd_base;

  always_ff @(posedge clk) begin
    if (!rstn || i_clr) begin
      for (int i = 0; i < NUM_BINS; i++) r_bin[i] <= '0;
    end else if (i_inc) begin
      r_bin[i_inc_idx] <= CNT_W'(sat_inc(32'(r_bin[i_inc_idx]), CNT_W));
    end
  end

  // Word k carries bins 4k..4k+3, lowest bin in the lowest lane.
  always_comb begin
    o_rd_word = '0;
    w_rd_base = {i_word_idx, 2'b00};
    for (int j = 0; j < BINS_PER_WORD; j++) begin
      o_rd_word[j*CNT_W +: CNT_W] = r_bin[w_rd_base + IDX_W'(j)];
    end
  end

endmodule

// File: rtl/noise_histogram_dump.sv
// noise_histogram_dump: bins a run of noise samples and writes the histogram to
// OCM port 2. Define HIST_MOMENTS_EN to append a {sum_sq, sum} word to the dump.
module noise_histogram_dump
  import noise_hist_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_BINS  = 128,
  parameter int CNT_W     = 16,
  parameter int NSAMP_W   = 24,
  parameter int ADDR_W    = 14,
  parameter int ADDR_STEP = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               en,
  input  logic               start,
  input  logic [NSAMP_W-1:0] num_samples,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [DATA_W-1:0]  sample_in,
  input  logic               sample_valid,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   clip_count,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_wen,
  output logic [63:0]        mem_wdata
);

  localparam int IDX_W  = $clog2(NUM_BINS);
  localparam int WIDX_W = $clog2(NUM_BINS / BINS_PER_WORD);
  localparam int WORD_W = WIDX_W + 1;
`ifdef HIST_MOMENTS_EN
  localparam int NUM_WORDS = WORDS_PER_DUMP + 1;
`else
  localparam int NUM_WORDS = WORDS_PER_DUMP;
`endif
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(NUM_WORDS - 1);

  state_t                    r_state, w_state_next;
  logic [NSAMP_W-1:0]        r_target, r_cnt, w_cnt_inc;
  logic [ADDR_W-1:0]         r_base;
  logic [CNT_W-1:0]          r_clip;
  logic [WORD_W-1:0]         r_word;
  logic [DATA_W:0]           w_biased;
  logic                      w_in_range, w_take, w_start;
  logic [BINS_PER_WORD*CNT_W-1:0] w_rd_word;

  // sample_valid is a one-way qualifier (no ready): a sample counts on any
  // clock edge where en && sample_valid are high while the FSM is in ACCUM.
  assign w_take    = en && sample_valid && (r_state == ACCUM);
  assign w_start   = en && start && (r_state == IDLE);
  assign w_cnt_inc = r_cnt + NSAMP_W'(1);
  assign w_biased  = {sample_in[DATA_W-1], sample_in} + (DATA_W+1)'(BIN_OFFSET);
  assign w_in_range = (w_biased < (DATA_W+1)'(NUM_BINS));
  assign clip_count = r_clip;

`ifdef HIST_MOMENTS_EN
  logic signed [DATA_W-1:0] w_samp;
  logic signed [31:0]       w_samp_ext;
  logic [31:0]              w_sq;
  logic [31:0]              r_sum, r_sq;
  assign w_samp     = sample_in;
  assign w_samp_ext = 32'(w_samp);
  assign w_sq       = w_samp_ext * w_samp_ext;
`endif

  hist_bin_bank #(
    .NUM_BINS (NUM_BINS),
    .CNT_W    (CNT_W)
  ) u_bank (
    .clk        (clk),
    .rstn       (rstn),
    .i_clr      (w_start),
    .i_inc      (w_take && w_in_range),
    .i_inc_idx  (w_biased[IDX_W-1:0]),
    .i_word_idx (r_word[WIDX_W-1:0]),
    .o_rd_word  (w_rd_word)
  );

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (en) begin
      case (r_state)
        IDLE:    if (start) w_state_next = (num_samples == '0) ? DUMP : ACCUM;
        ACCUM:   if (sample_valid && (w_cnt_inc == r_target)) w_state_next = DUMP;
        DUMP:    if (r_word == LAST_WORD) w_state_next = DONE;
        DONE:    w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (r_state == ACCUM) || (r_state == DUMP);
    done      = en && (r_state == DONE);
    mem_wen   = en && (r_state == DUMP);
    mem_addr  = '0;
    mem_wdata = '0;
    if (r_state == DUMP) begin
      mem_addr = r_base + ADDR_W'(32'(r_word) * 32'(ADDR_STEP));
      for (int j = 0; j < BINS_PER_WORD; j++) begin
        mem_wdata[16*j +: 16] = 16'(w_rd_word[j*CNT_W +: CNT_W]);
      end
`ifdef HIST_MOMENTS_EN
      if (r_word == WORD_W'(WORDS_PER_DUMP)) mem_wdata = {r_sq, r_sum};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_target <= '0;
      r_base   <= '0;
      r_cnt    <= '0;
      r_clip   <= '0;
      r_word   <= '0;
`ifdef HIST_MOMENTS_EN
      r_sum    <= '0;
      r_sq     <= '0;
`endif
    end else if (en) begin
      case (r_state)
        IDLE: if (start) begin
          r_target <= num_samples;
          r_base   <= base_addr;
          r_cnt    <= '0;
          r_clip   <= '0;
          r_word   <= '0;
`ifdef HIST_MOMENTS_EN
          r_sum    <= '0;
          r_sq     <= '0;
`endif
        end
        ACCUM: if (sample_valid) begin
          r_cnt <= w_cnt_inc;
          if (!w_in_range) r_clip <= CNT_W'(sat_inc(32'(r_clip), CNT_W));
`ifdef HIST_MOMENTS_EN
          r_sum <= r_sum + w_samp_ext;
          r_sq  <= r_sq + w_sq;
`endif
        end
        DUMP:    r_word <= r_word + WORD_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_noise_histogram_dump.sv
// Scoreboard bench for noise_histogram_dump: a histogram model predicts every
// OCM write; a negedge monitor pops and compares each write as it appears.
module tb_noise_histogram_dump;

  localparam int ADDR_W  = 14;
  localparam int NSAMP_W = 24;
  localparam int CNT_W   = 16;
`ifdef HIST_MOMENTS_EN
  localparam int NWORDS = 33;
`else
  localparam int NWORDS = 32;
`endif

  logic               clk = 1'b0;
  logic               rstn, en, start, sample_valid;
  logic [NSAMP_W-1:0] num_samples;
  logic [ADDR_W-1:0]  base_addr;
  logic [7:0]         sample_in;
  logic               busy, done, mem_wen;
  logic [CNT_W-1:0]   clip_count;
  logic [ADDR_W-1:0]  mem_addr;
  logic [63:0]        mem_wdata;

  noise_histogram_dump dut (
    .clk          (clk),
    .rstn         (rstn),
    .en           (en),
    .start        (start),
    .num_samples  (num_samples),
    .base_addr    (base_addr),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .busy         (busy),
    .done         (done),
    .clip_count   (clip_count),
    .mem_addr     (mem_addr),
    .mem_wen      (mem_wen),
    .mem_wdata    (mem_wdata)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  logic [ADDR_W+63:0] exp_q[$];
  logic [ADDR_W+63:0] mon_e;
  int smp[$];
  int total = 0, bad = 0;
  int done_seen = 0, exp_done = 0, wr_count = 0;
  int start_cyc = 0, first_wr_cyc = 0;
  bit first_pending = 1'b0, prev_wen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat16(input int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  // Reference model: count occurrences of the first n samples, clamp, and
  // lay the clamped counts out four per word at base + 4*k.
  task automatic model_run(input int n, input logic [ADDR_W-1:0] base, output int exp_clip);
    int hist[128];
    int clips;
    int s;
    logic [63:0] w;
    logic [ADDR_W-1:0] a;
`ifdef HIST_MOMENTS_EN
    logic [31:0] sum, sq;
    sum = 0;
    sq  = 0;
`endif
    clips = 0;
    foreach (hist[i]) hist[i] = 0;
    for (int i = 0; i < n; i++) begin
      s = smp[i];
      if (s >= -64 && s <= 63) hist[s + 64]++;
      else clips++;
`ifdef HIST_MOMENTS_EN
      sum += 32'(s);
      sq  += 32'(s * s);
`endif
    end
    for (int k = 0; k < 32; k++) begin
      for (int j = 0; j < 4; j++) w[16*j +: 16] = sat16(hist[4*k + j]);
      a = base + ADDR_W'(4 * k);
      exp_q.push_back({a, w});
    end
`ifdef HIST_MOMENTS_EN
    a = base + ADDR_W'(4 * 32);
    exp_q.push_back({a, sq, sum});
`endif
    exp_clip = int'(sat16(clips));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mem_wen) begin
      wr_count++;
      if (first_pending) begin
        first_wr_cyc  = cyc;
        first_pending = 1'b0;
      end
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(mem_wen), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(mon_e[ADDR_W+63:64]));
        check("wr_data", mem_wdata, mon_e[63:0]);
      end
    end
    if (done) begin
      done_seen++;
      check("done_follows_last_write", 64'(prev_wen), 64'd1);
      check("all_words_written_at_done", 64'(exp_q.size()), 64'd0);
    end
    prev_wen = mem_wen;
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input int n, input logic [ADDR_W-1:0] base);
    start         = 1'b1;
    num_samples   = NSAMP_W'(n);
    base_addr     = base;
    start_cyc     = cyc;
    first_pending = 1'b1;
    @(posedge clk); #1;
    start       = 1'b0;
    num_samples = NSAMP_W'($urandom);
    base_addr   = ADDR_W'($urandom);
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic drive_samples(input bit gaps);
    foreach (smp[i]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          sample_valid = 1'b0;
          sample_in    = 8'($urandom);
          @(posedge clk); #1;
        end
      end
      sample_valid = 1'b1;
      sample_in    = 8'(smp[i]);
      @(posedge clk); #1;
    end
    sample_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_pulse", 64'(seen), 64'd1);
    @(negedge clk);
    check("busy_low_after_done", 64'(busy), 64'd0);
    check("done_single_cycle", 64'(done), 64'd0);
  endtask

  task automatic run_full(input int n, input logic [ADDR_W-1:0] base, input bit gaps,
                          input int exp_lat);
    int ec;
    model_run(n, base, ec);
    exp_done++;
    do_start(n, base);
    drive_samples(gaps);
    wait_done(NWORDS + 40);
    check("clip_count", 64'(clip_count), 64'(ec));
    if (exp_lat > 0) check("start_to_first_write", 64'(first_wr_cyc - start_cyc), 64'(exp_lat));
  endtask

  task automatic wait_addr(input logic [ADDR_W-1:0] a);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (mem_wen && mem_addr == a) seen = 1'b1;
    end
    check("reached_dump_word", 64'(seen), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  int n, ec, wr_before, done_before;
  logic [ADDR_W-1:0] base;

  initial begin
    rstn = 1'b0; en = 1'b1; start = 1'b0; num_samples = '0; base_addr = '0;
    sample_in = '0; sample_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_wen", 64'(mem_wen), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", mem_wdata, 64'd0);
    check("rst_clip", 64'(clip_count), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Directed histogram with two trailing samples that must be ignored.
    smp = '{0, 0, 0, 1, 1, -1, -64, 63, 5, 0, 7, 7};
    run_full(10, 14'h0000, 1'b0, 11);

    // All samples out of range.
    smp = '{-100, 100, 64, -65};
    run_full(4, 14'h0100, 1'b1, 0);
    repeat (4) @(posedge clk);
    #1;
    check("clip_holds_after_done", 64'(clip_count), 64'd4);

    // Zero-length run dumps immediately.
    smp.delete();
    run_full(0, 14'h0200, 1'b0, 1);

    // Random runs; valid samples while idle must be ignored; first base wraps.
    for (int r = 0; r < 4; r++) begin
      sample_valid = 1'b1;
      repeat (3) begin
        sample_in = 8'($urandom);
        @(posedge clk); #1;
      end
      sample_valid = 1'b0;
      n = $urandom_range(1, 300);
      smp.delete();
      for (int i = 0; i < n + 2; i++) smp.push_back(int'($urandom_range(0, 159)) - 80);
      base = (r == 0) ? 14'h3FF0 : ADDR_W'($urandom);
      run_full(n, base, 1'b1, 0);
    end

    // en held low across dump word 10, then a start pulse while busy.
    smp.delete();
    for (int i = 0; i < 40; i++) smp.push_back(int'($urandom_range(0, 159)) - 80);
    base = 14'h00A0;
    model_run(40, base, ec);
    exp_done++;
    wr_before = wr_count;
    do_start(40, base);
    drive_samples(1'b0);
    wait_addr(base + 14'd36);
    @(posedge clk); #1;
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("wen_low_while_en_low", 64'(mem_wen), 64'd0);
      check("busy_held_while_en_low", 64'(busy), 64'd1);
    end
    @(posedge clk); #1;
    en = 1'b1; start = 1'b1; num_samples = 24'd3; base_addr = 14'h3000;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(NWORDS + 20);
    check("write_count_en_toggle", 64'(wr_count - wr_before), 64'(NWORDS));
    check("clip_en_toggle", 64'(clip_count), 64'(ec));

    // Reset during dump word 5 abandons the run.
    smp.delete();
    for (int i = 0; i < 20; i++) smp.push_back(int'($urandom_range(0, 127)) - 64);
    base = 14'h0040;
    model_run(20, base, ec);
    done_before = done_seen;
    do_start(20, base);
    drive_samples(1'b1);
    wait_addr(base + 14'd16);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wen_after_reset", 64'(mem_wen), 64'd0);
      check("busy_after_reset", 64'(busy), 64'd0);
      check("done_after_reset", 64'(done), 64'd0);
    end
    check("no_done_for_abandoned_run", 64'(done_seen - done_before), 64'd0);
    check("clip_after_reset", 64'(clip_count), 64'd0);

    // Fresh run must start from cleared bins.
    smp = '{3, 3, -2, 90, -64};
    run_full(5, 14'h0500, 1'b1, 0);

    // Saturation of a single bin.
    smp.delete();
    repeat (70000) smp.push_back(0);
    run_full(70000, 14'h0000, 1'b0, 70001);

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("done_count", 64'(done_seen), 64'(exp_done));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
